// File: rtl/regfile_dump.sv
// regfile_dump: sweeps a register-file address range through one read port and
// streams (addr, data) beats on valid/ready, flagging beats overwritten before
// they are consumed. Optional DUMP_CHECKSUM_EN appends a modular-sum beat and
// adds the csum_beat output.
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] wa,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_stale,
`ifdef DUMP_CHECKSUM_EN
  output logic              csum_beat,
`endif
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              issued_q, issued_d;
  logic              vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              olast_q, olast_d;
  logic              stale_q, stale_d;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              csent_q, csent_d;
  logic              cbeat_q, cbeat_d;
  logic              csum_load;
`endif

  logic running, slot, xfer, load, at_last, hit_ptr, hit_held, empty_rng;

  assign running   = (state_q == S_RUN);
  assign slot      = !vld_q || out_ready;
  assign xfer      = vld_q && out_ready;
  assign load      = running && !issued_q && slot;
  assign at_last   = (ptr_q == last_q);
  assign empty_rng = (first_addr > last_addr);
  // Writes land on the clock edge, so a hit on the address being captured
  // means the captured value is already out of date.
  assign hit_ptr   = regwrite && (wa == ptr_q) && (wa != '0);
  assign hit_held  = regwrite && (wa == addr_q) && (wa != '0);
`ifdef DUMP_CHECKSUM_EN
  assign csum_load = running && issued_q && !csent_q && slot;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    last_d   = last_q;
    issued_d = issued_q;
`ifdef DUMP_CHECKSUM_EN
    acc_d    = acc_q;
    csent_d  = csent_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d    = first_addr;
          last_d   = last_addr;
`ifdef DUMP_CHECKSUM_EN
          // An empty range still runs so the checksum beat (zero) goes out.
          acc_d    = '0;
          csent_d  = 1'b0;
          issued_d = empty_rng;
          state_d  = S_RUN;
`else
          issued_d = 1'b0;
          state_d  = empty_rng ? S_FIN : S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (xfer && olast_q) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      if (at_last) issued_d = 1'b1;
      else         ptr_d    = ptr_q + ADDR_W'(1);
`ifdef DUMP_CHECKSUM_EN
      acc_d = acc_q + rd;
`endif
    end
`ifdef DUMP_CHECKSUM_EN
    if (csum_load) csent_d = 1'b1;
`endif
  end

  always_comb begin
    vld_d   = vld_q;
    addr_d  = addr_q;
    data_d  = data_q;
    olast_d = olast_q;
    stale_d = stale_q;
`ifdef DUMP_CHECKSUM_EN
    cbeat_d = cbeat_q;
`endif
    if (load) begin
      vld_d   = 1'b1;
      addr_d  = ptr_q;
      data_d  = rd;
      stale_d = hit_ptr;
`ifdef DUMP_CHECKSUM_EN
      olast_d = 1'b0;
      cbeat_d = 1'b0;
`else
      olast_d = at_last;
`endif
    end
`ifdef DUMP_CHECKSUM_EN
    else if (csum_load) begin
      vld_d   = 1'b1;
      addr_d  = '0;
      data_d  = acc_q;
      olast_d = 1'b1;
      stale_d = 1'b0;
      cbeat_d = 1'b1;
    end
`endif
    else if (xfer) begin
      vld_d   = 1'b0;
      olast_d = 1'b0;
      stale_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      cbeat_d = 1'b0;
`endif
    end else if (vld_q && hit_held) begin
      stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      last_q   <= '0;
      issued_q <= 1'b0;
      vld_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      olast_q  <= 1'b0;
      stale_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc_q    <= '0;
      csent_q  <= 1'b0;
      cbeat_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      issued_q <= issued_d;
      vld_q    <= vld_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      olast_q  <= olast_d;
      stale_q  <= stale_d;
`ifdef DUMP_CHECKSUM_EN
      acc_q    <= acc_d;
      csent_q  <= csent_d;
      cbeat_q  <= cbeat_d;
`endif
    end
  end

  assign ra        = running ? ptr_q : '0;
  assign out_valid = vld_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_last  = olast_q;
  assign out_stale = stale_q;
`ifdef DUMP_CHECKSUM_EN
  assign csum_beat = cbeat_q;
`endif
  assign busy      = running;
  assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a behavioural register file plus a transaction-level
// model of the dump stream, checked every cycle with immediate assertions.
module tb_regfile_dump;
  logic        clk = 1'b0;
  logic        reset, start, regwrite, out_valid, out_ready, out_last, out_stale, busy, done;
  logic [4:0]  first_addr, last_addr, ra, wa, out_addr;
  logic [31:0] rd, out_data, wdata;
`ifdef DUMP_CHECKSUM_EN
  logic        csum_beat;
`endif

  regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .ra(ra), .rd(rd), .regwrite(regwrite), .wa(wa), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .out_stale(out_stale),
`ifdef DUMP_CHECKSUM_EN
    .csum_beat(csum_beat),
`endif
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rd = (ra == 5'd0) ? 32'd0 : rf[ra];
  always @(posedge clk) if (regwrite && wa != 5'd0) rf[wa] <= wdata;

  int checks = 0;
  int errors = 0;

  // Model: remaining addresses to capture (-1 = checksum beat) and one held beat.
  int          pend[$];
  bit          m_run, m_fin, m_held, h_wr, h_last, h_csum;
  logic [4:0]  h_addr;
  logic [31:0] h_data, m_sum;
  int          nbeats;
  logic [31:0] xq_data[$];
  bit          xq_stale[$];
  bit          xq_csum[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    m_run = 0; m_fin = 0; m_held = 0; h_wr = 0; h_last = 0; h_csum = 0;
    h_addr = 5'd0; h_data = 32'd0; m_sum = 32'd0;
  endtask

  task automatic mon();
    bit xfer, cap, run_n, fin_n;
    int item;
    chk("busy", busy, m_run);
    chk("done", done, m_fin);
    chk("out_valid", out_valid, m_held);
    if (!m_run) chk("ra_idle", ra, 32'd0);
    if (m_held) begin
      chk("out_addr", out_addr, h_addr);
      chk("out_data", out_data, h_data);
      chk("out_last", out_last, h_last);
      chk("out_stale", out_stale, h_wr);
`ifdef DUMP_CHECKSUM_EN
      chk("csum_beat", csum_beat, h_csum);
`endif
    end
    xfer  = m_held && out_ready;
    cap   = m_run && pend.size() > 0 && (!m_held || out_ready);
    run_n = m_run;
    fin_n = 0;
    if (xfer) begin
      nbeats++;
      xq_data.push_back(out_data);
      xq_stale.push_back(out_stale);
`ifdef DUMP_CHECKSUM_EN
      xq_csum.push_back(csum_beat);
`endif
      m_held = 0;
      if (h_last) begin run_n = 0; fin_n = 1; end
    end else if (m_held && regwrite && wa == h_addr && wa != 5'd0) begin
      h_wr = 1;
    end
    if (cap) begin
      item   = pend.pop_front();
      m_held = 1;
      if (item < 0) begin
        h_addr = 5'd0; h_data = m_sum; h_wr = 0; h_last = 1; h_csum = 1;
      end else begin
        h_addr = item[4:0];
        h_data = (item == 0) ? 32'd0 : rf[item];
        h_wr   = regwrite && wa == h_addr && h_addr != 5'd0;
        m_sum  = m_sum + h_data;
        h_csum = 0;
`ifdef DUMP_CHECKSUM_EN
        h_last = 0;
`else
        h_last = (pend.size() == 0);
`endif
      end
    end
    if (!m_run && !m_fin && start) begin
      for (int a = int'(first_addr); a <= int'(last_addr); a++) pend.push_back(a);
`ifdef DUMP_CHECKSUM_EN
      pend.push_back(-1);
`endif
      m_sum = 32'd0;
      if (pend.size() == 0) fin_n = 1;
      else                  run_n = 1;
    end
    m_run = run_n;
    m_fin = fin_n;
  endtask

  task automatic cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_chk();
    chk("rst_ra", ra, 32'd0);
    chk("rst_valid", out_valid, 32'd0);
    chk("rst_last", out_last, 32'd0);
    chk("rst_stale", out_stale, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_addr", out_addr, 32'd0);
    chk("rst_data", out_data, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1; start = 0; regwrite = 0;
    @(posedge clk);
    #1;
    model_clear();
    zero_chk();
    reset = 0;
  endtask

  // rmode: 0 ready high, 1 ready 1,0,0 repeating, 2 random ready plus noise on start/range.
  task automatic dump(input int f, input int l, input int rmode, input int wpct,
                      input int stop_after, input int maxc);
    int k = 0;
    int exp_n;
    nbeats = 0;
    xq_data.delete(); xq_stale.delete(); xq_csum.delete();
    exp_n = (l >= f) ? l - f + 1 : 0;
`ifdef DUMP_CHECKSUM_EN
    exp_n++;
`endif
    first_addr = f[4:0]; last_addr = l[4:0]; start = 1; out_ready = 1; regwrite = 0;
    cycle();
    start = 0;
    while ((m_run || m_fin) && k < maxc && !(stop_after > 0 && nbeats >= stop_after)) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 3 == 0) : ($urandom_range(3) != 0);
      regwrite  = ($urandom_range(99) < wpct);
      wa        = 5'($urandom_range(31));
      wdata     = $urandom;
      start     = (rmode == 2) && ($urandom_range(7) == 0);
      if (rmode == 2) begin first_addr = 5'($urandom); last_addr = 5'($urandom); end
      k++;
      cycle();
    end
    start = 0; regwrite = 0;
    if (stop_after == 0) begin
      chk("dump_ended", m_run || m_fin, 32'd0);
      chk("beat_count", nbeats, exp_n);
    end
  endtask

  initial begin
    reset = 1; start = 0; first_addr = 0; last_addr = 0; regwrite = 0; wa = 0; wdata = 0; out_ready = 0;
    nbeats = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    zero_chk();
    reset = 0;

    for (int n = 1; n < 32; n++) begin
      regwrite = 1; wa = n[4:0]; wdata = 32'h100 + n;
      cycle();
    end
    regwrite = 0;

    dump(0, 31, 0, 0, 0, 100);
`ifndef DUMP_CHECKSUM_EN
    chk("full_x31", xq_data[31], 32'h11F);
`endif
    dump(5, 7, 1, 0, 0, 60);
    dump(9, 3, 0, 0, 0, 20);

    // Held beat overwritten, next register overwritten before its read.
    first_addr = 10; last_addr = 12; start = 1; out_ready = 0;
    nbeats = 0; xq_data.delete(); xq_stale.delete(); xq_csum.delete();
    cycle();
    start = 0;
    cycle();
    regwrite = 1; wa = 5'd10; wdata = 32'hDEAD;
    cycle();
    wa = 5'd11; wdata = 32'hBEEF;
    cycle();
    regwrite = 0; out_ready = 1;
    for (int k = 0; k < 20 && (m_run || m_fin); k++) cycle();
    chk("x10_old", xq_data[0], 32'h10A);
    chk("x10_stale", xq_stale[0], 32'd1);
    chk("x11_new", xq_data[1], 32'hBEEF);
    chk("x11_fresh", xq_stale[1], 32'd0);

    dump(0, 31, 0, 0, 2, 50);
    do_reset();
    cycle();
    dump(4, 8, 2, 30, 0, 200);

    for (int t = 0; t < 12; t++)
      dump($urandom_range(31), $urandom_range(31), 2, 30, 0, 400);

`ifdef DUMP_CHECKSUM_EN
    regwrite = 1; wa = 5'd1; wdata = 32'hFFFF_FFFF; cycle();
    wa = 5'd2; wdata = 32'd2; cycle();
    wa = 5'd3; wdata = 32'd3; cycle();
    regwrite = 0;
    dump(1, 3, 0, 0, 0, 40);
    chk("csum_value", xq_data[3], 32'd4);
    chk("csum_flag", xq_csum[3], 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Sequential reader for the processor's 32x32 register file.
- On a start pulse it sweeps an address range through one combinational read port and streams each (address, data) pair out on a valid/ready interface.
- It snoops the register-file write port so that any beat overwritten before it is consumed is flagged stale.
- Used for debug register dumps and end-of-test state checks, with no changes to the register file itself.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin dump; sampled only in IDLE.
- first_addr  input  ADDR_W  first register of the range, latched on start.
- last_addr  input  ADDR_W  last register of the range (inclusive), latched on start.
- ra  output  ADDR_W  read address to the register-file read port.
- rd  input  DATA_W  combinational read data for ra.
- regwrite  input  1  snoop of register-file write enable.
- wa  input  ADDR_W  snoop of register-file write address.
- out_valid  output  1  beat available.
- out_ready  input  1  consumer accepts beat.
- out_addr  output  ADDR_W  register address of beat.
- out_data  output  DATA_W  register value of beat.
- out_last  output  1  final beat of dump.
- out_stale  output  1  beat's register was written after capture.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse at dump completion.

Behaviour:
- Interface: one clock, synchronous active-high reset. Clock port is clk, reset port is reset.
- Reset: all outputs 0 (ra=0, out_valid=0, out_last=0, out_stale=0, busy=0, done=0). State goes to IDLE and the pointer clears.
- Reset mid-dump aborts the dump; no done pulse is produced.
- States:
  - IDLE: busy=0, ra=0. On start: latch first/last, ptr=first_addr, go to RUN.
  - RUN: busy=1, ra=ptr.
  - FIN: one cycle, done=1, busy=0, then back to IDLE.
- Empty range: if first_addr > last_addr at start, go to FIN directly. No beats are emitted and done pulses on the cycle after start.
- start while busy is ignored.
- Capture:
  - In RUN, load = !issued_all && (!out_valid || out_ready).
  - On load: out_data<=rd, out_addr<=ptr, out_last<=(ptr==last_addr), out_valid<=1.
  - If ptr==last_addr, set issued_all; otherwise ptr<=ptr+1.
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - out_* stay stable while out_valid && !out_ready.
  - If out_valid && out_ready && no load, out_valid<=0.
- Throughput and latency:
  - One beat per cycle with out_ready held high, no bubbles.
  - First out_valid rises 2 cycles after the start cycle.
- Completion: transfer of the out_last beat causes FIN on the next cycle (done pulse). busy is high from the cycle after start through the last-beat transfer.
- Address 0: read normally; the register file supplies 0, and the block does no special-casing.
- Full range: first=0, last=31 emits 32 beats. ptr never wraps because issued_all stops increments at 31.
- Write-collision rules (register-file write lands on the clock edge):
  - Same-cycle write to ra on a load cycle: the captured value is the old one, and out_stale is set with the beat (if wa!=0).
  - While out_valid, regwrite && wa==out_addr && wa!=0 sets out_stale for the held beat.
  - out_stale clears when a new beat loads or the beat transfers without reload.
  - Writes to already-transferred or not-yet-read registers have no effect on flags.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A DATA_W accumulator, cleared on start, adds each loaded out_data modulo 2^DATA_W.
  - After the last register beat transfers, one extra beat is emitted: out_addr=0, out_data=sum, out_stale=0, out_last=1.
  - The register beat for last_addr has out_last=0.
  - Extra output csum_beat (1 bit) is high only on that beat.
  - done follows transfer of the checksum beat.
  - An empty range emits the checksum beat with value 0.
- Not defined: no accumulator, no csum_beat port, behaviour exactly as above.

Test Plan:
- Regfile preloaded x1..x31 = 0x100+n; start with first=0, last=31, out_ready=1 -> 32 beats, addr 0..31 consecutive cycles, data 0, 0x101..0x11F, out_last only on addr 31, done 1 cycle after it.
- first=5, last=7, out_ready toggled 1,0,0,1,... -> beats addr 5,6,7 each held stable while not ready, no drops or duplicates, busy falls with done.
- first=9, last=3 -> no out_valid; done on the cycle after start; busy stays 0.
- Range 10..12, out_ready=0 after capture of x10; write x10=0xDEAD -> held beat keeps the old value with out_stale=1; a write to x11 before its read -> x11 beat returns 0xDEAD-style new data, stale=0.
- Assert reset mid-dump (after 2 beats) -> next cycle all outputs 0, no done. A new start then dumps normally.
- With DUMP_CHECKSUM_EN, range 1..3 holding 0xFFFFFFFF, 2, 3 -> fourth beat addr 0 data 0x00000004, csum_beat=1, out_last=1.
